// File: rtl/sram_load_verify_ctrl.sv
// sram_load_verify_ctrl: SRAM preload / readback-verify engine over a wrapping base/length window; define SRAM_LDV_MISMATCH_LOG_EN for first-mismatch capture
module sram_load_verify_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 108,
  parameter int RD_LAT = 1,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              mis_valid,
  output logic [ADDR_W-1:0] mis_addr,
  output logic [DATA_W-1:0] mis_data
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] rem;
  logic [2:0] fcnt;
  logic acc, last, mism;
  logic [RD_LAT:0] pv;
  logic [DATA_W-1:0] pd [RD_LAT+1];
  // Handshakes and next state; the final accepted word ends the streaming phase
  always_comb begin
    cmd_ready = state == IDLE;
    in_ready = state == WRITE || state == READ;
    busy = state != IDLE;
    acc = in_valid && in_ready;
    last = acc && rem == 1;
    state_nx = state == IDLE  ? (cmd_valid ? (cmd_len == '0 ? DONE : cmd_mode ? READ : WRITE) : IDLE)
             : state == WRITE ? (last ? DONE : WRITE)
             : state == READ  ? (last ? FLUSH : READ)
             : state == FLUSH ? (fcnt == '0 ? DONE : FLUSH)
             : IDLE;
  end
  // State, window walk, registered SRAM port, done pulse and saturating error count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      fcnt <= '0;
      sram_cen <= 1'b1;
      sram_wen <= 1'b1;
      sram_a <= '0;
      sram_d <= '0;
      done <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nx;
      done <= state == DONE;
      fcnt <= state == READ ? 3'(RD_LAT - 1) : fcnt - 3'd1;
      if (cmd_ready && cmd_valid) begin
        addr <= cmd_base;
        rem <= cmd_len;
      end else if (acc) begin
        addr <= addr == LAST ? '0 : addr + 1'b1;
        rem <= rem - 1'b1;
      end
      sram_cen <= !acc;
      sram_wen <= !(acc && state == WRITE);
      if (acc) sram_a <= addr;
      if (acc && state == WRITE) sram_d <= in_data;
      if (cmd_ready && cmd_valid) err_cnt <= '0;
      else if (mism && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
  // Expected-word tags travel alongside the SRAM read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pv <= '0;
    else pv <= {pv[RD_LAT-1:0], acc && state == READ};
  end
  // Expected-word payload needs no reset; its tag qualifies it
  always_ff @(posedge clk) begin
    pd[0] <= in_data;
    for (int k = 1; k <= RD_LAT; k++) pd[k] <= pd[k-1];
  end
  assign mism = pv[RD_LAT] && sram_q != pd[RD_LAT];
`ifdef SRAM_LDV_MISMATCH_LOG_EN
  logic [ADDR_W-1:0] pa [RD_LAT+1];
  // Address of each in-flight read, for reporting where a mismatch occurred
  always_ff @(posedge clk) begin
    pa[0] <= addr;
    for (int k = 1; k <= RD_LAT; k++) pa[k] <= pa[k-1];
  end
  // First mismatch of a command is captured and held; later ones are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mis_valid <= 1'b0;
      mis_addr <= '0;
      mis_data <= '0;
    end else if (cmd_ready && cmd_valid) begin
      mis_valid <= 1'b0;
      mis_addr <= '0;
      mis_data <= '0;
    end else if (mism && !mis_valid) begin
      mis_valid <= 1'b1;
      mis_addr <= pa[RD_LAT];
      mis_data <= sram_q;
    end
  end
`else
  assign mis_valid = 1'b0;
  assign mis_addr = '0;
  assign mis_data = '0;
`endif
endmodule

// File: tb/tb_sram_load_verify_ctrl.sv
// tb_sram_load_verify_ctrl: randomized scoreboard bench with SRAM model and reference memory
module tb_sram_load_verify_ctrl;
  localparam int DATA_W = 32, ADDR_W = 7, DEPTH = 108, RD_LAT = 2, ERR_W = 16;
`ifdef SRAM_LDV_MISMATCH_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_mode = 0, in_valid = 0;
  logic [ADDR_W-1:0] cmd_base = '0;
  logic [ADDR_W:0] cmd_len = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic cmd_ready, in_ready, sram_cen, sram_wen, busy, done, mis_valid;
  logic [ADDR_W-1:0] sram_a, mis_addr;
  logic [DATA_W-1:0] sram_d, sram_q, mis_data;
  logic [ERR_W-1:0] err_cnt;
  logic s_cmd_ready, s_in_ready, s_cen, s_wen, s_busy, s_done, s_mv;
  logic [ADDR_W-1:0] s_a, s_ma;
  logic [DATA_W-1:0] s_d, s_md;
  logic [1:0] s_err;

  sram_load_verify_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q),
    .busy(busy), .done(done), .err_cnt(err_cnt), .mis_valid(mis_valid), .mis_addr(mis_addr), .mis_data(mis_data));

  sram_load_verify_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .ERR_W(2)) u_sat (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready), .cmd_mode(cmd_mode),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .sram_cen(s_cen), .sram_wen(s_wen), .sram_a(s_a), .sram_d(s_d), .sram_q(sram_q),
    .busy(s_busy), .done(s_done), .err_cnt(s_err), .mis_valid(s_mv), .mis_addr(s_ma), .mis_data(s_md));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] qp [RD_LAT];
  always @(posedge clk) begin
    if (!sram_cen && !sram_wen) mem[sram_a] <= sram_d;
    qp[0] <= (!sram_cen && sram_wen) ? mem[sram_a] : $urandom;
    for (int k = 1; k < RD_LAT; k++) qp[k] <= qp[k-1];
  end
  assign sram_q = qp[RD_LAT-1];

  typedef struct {int cyc; int err; bit mv; int ma; logic [DATA_W-1:0] md;} done_t;
  typedef struct {int a; logic [DATA_W-1:0] d;} wr_t;
  done_t sbq[$];
  wr_t wq[$];
  int rq[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  wr_t mw;
  done_t me;
  int mra;
  always @(negedge clk) if (!reset) begin
    if (!sram_cen && !sram_wen) begin
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        mw = wq.pop_front();
        chk("wr_addr", 64'(sram_a), 64'(mw.a));
        chk("wr_data", 64'(sram_d), 64'(mw.d));
      end
    end
    if (!sram_cen && sram_wen) begin
      if (rq.size() == 0) chk("unexpected_read", 1, 0);
      else begin
        mra = rq.pop_front();
        chk("rd_addr", 64'(sram_a), 64'(mra));
      end
    end
    if (done) begin
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = sbq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(me.cyc));
        chk("err_cnt", 64'(err_cnt), 64'(me.err));
        chk("err_cnt_sat2", 64'(s_err), 64'(me.err > 3 ? 3 : me.err));
        chk("sat_done", 64'(s_done), 1);
        chk("mis_valid", 64'(mis_valid), 64'(me.mv));
        chk("mis_addr", 64'(mis_addr), 64'(me.ma));
        chk("mis_data", 64'(mis_data), 64'(me.md));
      end
    end
  end

  task automatic run_cmd(input bit mode, input int base, input int len, input int stall,
                         input int pct, input int bad_idx, input int abort);
    int i, g, m, a, err, first_a;
    logic [DATA_W-1:0] w, first_d;
    bit v, bad;
    done_t e;
    @(negedge clk);
    cmd_valid = 1; cmd_mode = mode; cmd_base = ADDR_W'(base); cmd_len = (ADDR_W+1)'(len);
    g = 0;
    while (!cmd_ready && g < 300) begin @(negedge clk); g++; end
    chk("cmd_ready", 64'(cmd_ready), 1);
    m = cyc; a = base; err = 0; first_a = -1; first_d = '0;
    @(negedge clk);
    cmd_valid = 0;
    i = 0; g = 0;
    while (i < len && g < 4 * len + 20) begin
      v = stall == 0 ? 1'b1 : stall == 1 ? (g % 2) == 1 : $urandom_range(1, 0) == 1;
      w = mode ? ref_mem[a] : $urandom;
      bad = mode && (i == bad_idx || int'($urandom_range(99, 0)) < pct);
      if (bad) w = w ^ ($urandom | 32'd1);
      in_valid = v; in_data = w;
      if (v && in_ready) begin
        m = cyc;
        if (abort > 0 && i == abort - 1) begin
          @(posedge clk);
          #1 reset = 1;
          #1;
          chk("rst_cen", 64'(sram_cen), 1);
          chk("rst_wen", 64'(sram_wen), 1);
          chk("rst_cmd_ready", 64'(cmd_ready), 1);
          chk("rst_done", 64'(done), 0);
          in_valid = 0;
          repeat (2) @(negedge clk);
          reset = 0;
          #1;
          chk("post_rst_ready", 64'(cmd_ready), 1);
          chk("post_rst_busy", 64'(busy), 0);
          chk("post_rst_err", 64'(err_cnt), 0);
          return;
        end
        if (mode) begin
          rq.push_back(a);
          if (bad) begin
            err++;
            if (first_a < 0) begin first_a = a; first_d = ref_mem[a]; end
          end
        end else begin
          wq.push_back('{a, w});
          ref_mem[a] = w;
        end
        a = (a + 1) % DEPTH;
        i++;
      end
      g++;
      @(negedge clk);
    end
    in_valid = 0;
    chk("words_accepted", 64'(i), 64'(len));
    e.cyc = m + ((mode && len > 0) ? RD_LAT + 2 : 2);
    e.err = err;
    e.mv = LOG && first_a >= 0;
    e.ma = (LOG && first_a >= 0) ? first_a : 0;
    e.md = (LOG && first_a >= 0) ? first_d : '0;
    sbq.push_back(e);
  endtask

  initial begin
    int g;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 1);
    chk("reset_in_ready", 64'(in_ready), 0);
    chk("reset_cen", 64'(sram_cen), 1);
    chk("reset_wen", 64'(sram_wen), 1);
    chk("reset_a", 64'(sram_a), 0);
    chk("reset_d", 64'(sram_d), 0);
    chk("reset_busy", 64'(busy), 0);
    chk("reset_done", 64'(done), 0);
    chk("reset_err", 64'(err_cnt), 0);
    chk("reset_mis", {mis_valid, 25'(mis_addr), mis_data}, 0);
    reset = 0;
    run_cmd(0, 0, DEPTH, 0, 0, -1, 0);
    run_cmd(0, 0, 72, 0, 0, -1, 0);
    run_cmd(1, 0, 72, 0, 0, -1, 0);
    run_cmd(1, 0, 72, 0, 0, 5, 0);
    run_cmd(0, 100, 16, 0, 0, -1, 0);
    run_cmd(1, 100, 16, 0, 0, -1, 0);
    run_cmd(0, 3, 0, 0, 0, -1, 0);
    run_cmd(1, 3, 0, 0, 0, -1, 0);
    run_cmd(0, 20, 8, 1, 0, -1, 0);
    run_cmd(1, 20, 8, 1, 0, -1, 0);
    run_cmd(1, 0, 6, 0, 100, -1, 0);
    for (int t = 0; t < 14; t++)
      run_cmd($urandom_range(1, 0) == 1, int'($urandom_range(DEPTH - 1, 0)), int'($urandom_range(150, 0)), 2, 10, -1, 0);
    run_cmd(0, 50, 30, 0, 0, -1, 10);
    repeat (10) @(negedge clk);
    run_cmd(1, 0, DEPTH, 2, 0, -1, 0);
    g = 0;
    while ((sbq.size() + wq.size() + rq.size()) != 0 && g < 500) begin @(negedge clk); g++; end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size() + wq.size() + rq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
